// File: rtl/heapsort_stim_serializer.sv
// Unpacks a packed HeapSort stimulus word and pushes its keys, one per
// handshake, into the heap-sort core insert port; counts completed batches.
module heapsort_stim_serializer #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic [N_ELEM*ELEM_W:0]   stim_i,
  output logic                     stim_ready_o,
  output logic                     push_valid_o,
  output logic [ELEM_W-1:0]        push_data_o,
  output logic                     push_last_o,
  input  logic                     push_ready_i,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         batch_cnt_o
);

  // state | meaning
  // IDLE  | waiting for a valid stimulus word, stim_ready_o high
  // SEND  | presenting payload key[idx] to the heap core

  localparam int PAY_W = N_ELEM * ELEM_W;
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  state_t             next_state;
  logic [PAY_W-1:0]   payload;
  logic [IDX_W-1:0]   idx;
  logic               capture;
  logic               handshake;
  logic               at_last;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) state <= IDLE;
    else                  state <= next_state;
  end

  always_comb begin
    next_state   = state;
    stim_ready_o = 1'b0;
    push_valid_o = 1'b0;
    push_last_o  = 1'b0;
    push_data_o  = '0;
    busy_o       = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    unique case (state)
      IDLE: begin
        stim_ready_o = 1'b1;
        if (stim_i[PAY_W]) begin
          capture    = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        busy_o       = 1'b1;
        push_valid_o = 1'b1;
        push_last_o  = at_last;
        push_data_o  = payload[idx*ELEM_W +: ELEM_W];
        handshake    = push_ready_i;
        if (push_ready_i && at_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // idx only advances on a handshake, so data/last hold under backpressure
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      payload     <= '0;
      idx         <= '0;
      batch_cnt_o <= '0;
    end else if (capture) begin
      payload <= stim_i[PAY_W-1:0];
      idx     <= '0;
    end else if (handshake) begin
      if (at_last) batch_cnt_o <= batch_cnt_o + 1'b1;
      else         idx         <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_heapsort_stim_serializer.sv
// Directed bench for heapsort_stim_serializer: reset, single batch, backpressure,
// back-to-back batches, mid-batch reset and counter wrap (small-counter instance).
module tb_heapsort_stim_serializer;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [160:0]  stim = '0;
  logic          ready = 1'b1;
  logic          stim_ready, push_valid, push_last, busy;
  logic [15:0]   push_data;
  logic [15:0]   batch_cnt;

  logic [32:0]   stim2 = '0;
  logic          ready2 = 1'b1;
  logic          stim_ready2, push_valid2, push_last2, busy2;
  logic [15:0]   push_data2;
  logic [2:0]    batch_cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  heapsort_stim_serializer dut (
    .system1000(clk), .system1000_rstn(rstn), .stim_i(stim),
    .stim_ready_o(stim_ready), .push_valid_o(push_valid), .push_data_o(push_data),
    .push_last_o(push_last), .push_ready_i(ready), .busy_o(busy), .batch_cnt_o(batch_cnt)
  );

  heapsort_stim_serializer #(.ELEM_W(16), .N_ELEM(2), .CNT_W(3)) dut_wrap (
    .system1000(clk), .system1000_rstn(rstn), .stim_i(stim2),
    .stim_ready_o(stim_ready2), .push_valid_o(push_valid2), .push_data_o(push_data2),
    .push_last_o(push_last2), .push_ready_i(ready2), .busy_o(busy2), .batch_cnt_o(batch_cnt2)
  );

  function automatic logic [160:0] mk_word(input logic [15:0] start, input logic [15:0] step);
    logic [160:0] w;
    w = '0;
    for (int k = 0; k < 10; k++) w[k*16 +: 16] = start + step * 16'(k);
    w[160] = 1'b1;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    stim = mk_word(16'h0055, 16'h0001);
    repeat (3) begin
      tick();
      total++;
      if (push_valid !== 1'b0 || busy !== 1'b0 || batch_cnt !== 16'd0 || push_data !== 16'd0) begin
        bad++;
        $display("FAIL reset_outputs got valid=%b busy=%b cnt=%0d data=%h exp 0 0 0 0",
                 push_valid, busy, batch_cnt, push_data);
      end
    end
    rstn = 1'b1;
    #1;
    total++;
    if (stim_ready !== 1'b1 || push_valid !== 1'b0 || push_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got ready=%b valid=%b last=%b exp 1 0 0",
               stim_ready, push_valid, push_last);
    end
    stim = '0;
    tick();
  endtask

  task automatic test_single();
    stim = mk_word(16'd9, 16'hFFFF);
    tick();
    stim = '0;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (push_valid !== 1'b1 || push_data !== 16'(9 - k) || push_last !== (k == 9) || stim_ready !== 1'b0) begin
        bad++;
        $display("FAIL single_key k=%0d got valid=%b data=%0d last=%b sready=%b exp 1 %0d %b 0",
                 k, push_valid, push_data, push_last, stim_ready, 9 - k, k == 9);
      end
      tick();
    end
    total++;
    if (push_valid !== 1'b0 || batch_cnt !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end got valid=%b cnt=%0d busy=%b exp 0 1 0", push_valid, batch_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_key;
    int hs;
    hs = 0;
    stim = mk_word(16'h1000, 16'h0111);
    tick();
    stim = '0;
    for (int k = 0; k < 10; k++) begin
      exp_key = 16'h1000 + 16'h0111 * 16'(k);
      if (k == 3) begin
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          total++;
          if (push_valid !== 1'b1 || push_data !== 16'h1333 || push_last !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold s=%0d got valid=%b data=%h last=%b exp 1 1333 0",
                     s, push_valid, push_data, push_last);
          end
          tick();
        end
        ready = 1'b1;
      end
      total++;
      if (push_valid !== 1'b1 || push_data !== exp_key || push_last !== (k == 9)) begin
        bad++;
        $display("FAIL bp_key k=%0d got valid=%b data=%h last=%b exp 1 %h %b",
                 k, push_valid, push_data, push_last, exp_key, k == 9);
      end
      if (push_valid === 1'b1 && ready) hs++;
      tick();
    end
    if (push_valid === 1'b1) hs++;
    total++;
    if (hs != 10 || batch_cnt !== 16'd2) begin
      bad++;
      $display("FAIL bp_end got handshakes=%0d cnt=%0d exp 10 2", hs, batch_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_valid;
    logic [15:0] exp_data;
    stim = mk_word(16'hFFFF, 16'h0000);
    tick();
    stim = mk_word(16'h0000, 16'h0000);
    for (int c = 1; c <= 21; c++) begin
      exp_valid = (c != 11);
      exp_data  = (c <= 10) ? 16'hFFFF : 16'h0000;
      total++;
      if (push_valid !== exp_valid || (exp_valid && push_data !== exp_data) ||
          push_last !== (c == 10 || c == 21)) begin
        bad++;
        $display("FAIL b2b_cycle c=%0d got valid=%b data=%h last=%b exp %b %h %b",
                 c, push_valid, push_data, push_last, exp_valid, exp_data, c == 10 || c == 21);
      end
      if (c == 12) stim = '0;
      tick();
    end
    total++;
    if (push_valid !== 1'b0 || batch_cnt !== 16'd4) begin
      bad++;
      $display("FAIL b2b_end got valid=%b cnt=%0d exp 0 4", push_valid, batch_cnt);
    end
  endtask

  task automatic test_mid_reset();
    stim = mk_word(16'h0A00, 16'h0001);
    tick();
    stim = '0;
    repeat (4) tick();
    total++;
    if (push_valid !== 1'b1 || push_data !== 16'h0A04) begin
      bad++;
      $display("FAIL midrst_pre got valid=%b data=%h exp 1 0a04", push_valid, push_data);
    end
    rstn = 1'b0;
    #1;
    total++;
    if (push_valid !== 1'b0 || push_last !== 1'b0 || push_data !== 16'd0 ||
        busy !== 1'b0 || batch_cnt !== 16'd0 || stim_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_clear got valid=%b last=%b data=%h busy=%b cnt=%0d sready=%b exp 0 0 0 0 0 1",
               push_valid, push_last, push_data, busy, batch_cnt, stim_ready);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    stim = mk_word(16'h0B00, 16'h0002);
    tick();
    stim = '0;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (push_valid !== 1'b1 || push_data !== 16'h0B00 + 16'(2 * k) || push_last !== (k == 9)) begin
        bad++;
        $display("FAIL midrst_resume k=%0d got valid=%b data=%h last=%b exp 1 %h %b",
                 k, push_valid, push_data, push_last, 16'h0B00 + 16'(2 * k), k == 9);
      end
      tick();
    end
    total++;
    if (batch_cnt !== 16'd1) begin
      bad++;
      $display("FAIL midrst_cnt got cnt=%0d exp 1", batch_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    for (int b = 0; b < 8; b++) begin
      stim2 = {1'b1, 16'(b + 16'h0100), 16'(b)};
      tick();
      stim2 = '0;
      total++;
      if (push_valid2 !== 1'b1 || push_data2 !== 16'(b) || push_last2 !== 1'b0) begin
        bad++;
        $display("FAIL wrap_key0 b=%0d got valid=%b data=%h last=%b exp 1 %h 0",
                 b, push_valid2, push_data2, push_last2, 16'(b));
      end
      tick();
      total++;
      if (push_data2 !== 16'(b + 16'h0100) || push_last2 !== 1'b1) begin
        bad++;
        $display("FAIL wrap_key1 b=%0d got data=%h last=%b exp %h 1",
                 b, push_data2, push_last2, 16'(b + 16'h0100));
      end
      tick();
      total++;
      if (batch_cnt2 !== 3'(b + 1)) begin
        bad++;
        $display("FAIL wrap_cnt b=%0d got cnt=%0d exp %0d", b, batch_cnt2, (b + 1) % 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
